mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1: ALU-stage result valid this cycle.
REQ-004 SHALL have port alu_result, input, 32: ALU result; memory address for load/store.
REQ-005 SHALL have port store_data, input, 32: register-B data for stores.
REQ-006 SHALL have port regD_in, input, 5: destination register index.
REQ-007 SHALL have ports mem_read and mem_write, input, 1 each: access type; both low means ALU op.
REQ-008 SHALL have port is_byte, input, 1: byte access (1) or word access (0).
REQ-009 SHALL have port stall, output, 1: upstream holds its outputs while high.
REQ-010 SHALL have ports mem_req, mem_we, output, 1 each; mem_addr, mem_wdata, output, 32 each; mem_be, output, 4: data-memory request.
REQ-011 SHALL have ports mem_rdata, input, 32, and mem_ack, input, 1: memory response.
REQ-012 SHALL have ports wb_valid, wb_en, output, 1 each; wb_data, output, 32; wb_regD, output, 5: write-back result.
REQ-013 SHALL have port misalign, output, 1: sticky misaligned-word-access flag.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY; reset state IDLE.
REQ-015 IDLE, in_valid=1, no memory op: next edge wb_valid=1, wb_data=alu_result, wb_regD=regD_in, wb_en=(regD_in!=0); latency 1 cycle; stall=0.
REQ-016 IDLE, in_valid=1, memory op, aligned: next edge latch request, mem_req=1, go BUSY; stall=1 combinationally in this cycle.
REQ-017 mem_addr = {alu_result[31:2],2'b00}; mem_we=1 for writes; mem_read and mem_write both high SHALL be treated as write.
REQ-018 Word store: mem_wdata=store_data, mem_be=4'b1111. Byte store: mem_wdata=store_data[7:0] replicated 4x, mem_be one-hot at bit alu_result[1:0].
REQ-019 BUSY: mem_req and all request fields SHALL stay stable until the cycle mem_ack=1; stall=1 except in the mem_ack cycle, where stall=0.
REQ-020 BUSY, mem_ack=1: next edge mem_req=0, state IDLE, wb_valid=1; loads: wb_en=(latched regD!=0), wb_data=word or zero-extended byte lane alu_result[1:0]; stores: wb_en=0.
REQ-021 mem_ack while IDLE SHALL be ignored.
REQ-022 Word access with alu_result[1:0]!=0: no memory request, misalign set to 1 next edge, wb_valid=1 with wb_en=0, stall=0.
REQ-023 wb_valid SHALL be a one-cycle pulse per accepted in_valid; wb_data/wb_regD hold between pulses.
REQ-024 in_valid while in BUSY SHALL be ignored (upstream stalled).

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_en=0, wb_data=0, wb_regD=0, misalign=0; stall=0.
REQ-026 reset asserted in BUSY SHALL abandon the pending access without write-back; a mem_ack arriving after reset deasserts is ignored.

Configuration
REQ-027 Macro MEM_TIMEOUT_EN defined: 8-bit counter cleared on entry to BUSY, incremented each BUSY cycle without mem_ack; at 255 the access aborts: state IDLE, mem_req=0, wb_valid=1, wb_en=0, output timeout (1 bit, sticky, reset 0) set.
REQ-028 MEM_TIMEOUT_EN undefined: no counter, no timeout port; BUSY waits indefinitely for mem_ack.

Verification
REQ-029 ALU op: alu_result=0x0000_0042, regD_in=5, in_valid 1 cycle -> next cycle wb_valid=1, wb_en=1, wb_data=0x42, wb_regD=5, stall never high.
REQ-030 Word load addr 0x100, regD_in=3, mem_ack after 3 cycles with mem_rdata=0xDEAD_BEEF -> stall high 3 cycles, mem_addr=0x100, mem_be=1111, then wb_data=0xDEAD_BEEF, wb_regD=3, wb_en=1.
REQ-031 Byte store addr 0x203, store_data=0x0000_00A5, ack after 1 cycle -> mem_we=1, mem_be=1000, mem_wdata=0xA5A5_A5A5, wb_valid=1 with wb_en=0.
REQ-032 Byte load addr 0x101, mem_rdata=0x1122_3344 -> wb_data=0x0000_0033; word load addr 0x102 -> no mem_req, misalign=1, wb_en=0.
REQ-033 Reset pulled low on 2nd BUSY cycle of a load -> mem_req low same cycle, no wb_valid; later stray mem_ack produces no output.
REQ-034 With MEM_TIMEOUT_EN: load, mem_ack never asserted -> after 255 BUSY cycles mem_req=0, timeout=1, wb_valid=1, wb_en=0.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline memory stage. Forwards ALU results straight to
//            write-back and turns load/store operations into a single
//            outstanding data-memory request. The request is held stable
//            until the memory acknowledges it.
// Ports    : clk, reset (async, active-low)
//            in_valid, alu_result, store_data, regD_in, mem_read, mem_write,
//            is_byte                      - operation from the ALU stage
//            stall                        - holds the upstream stage
//            mem_req, mem_we, mem_addr, mem_wdata, mem_be
//                                         - data-memory request
//            mem_rdata, mem_ack           - data-memory response
//            wb_valid, wb_en, wb_data, wb_regD
//                                         - write-back result
//            misalign                     - sticky misaligned-word flag
//            timeout                      - sticky aborted-access flag
//                                           (MEM_TIMEOUT_EN builds only)
// Config   : `define MEM_TIMEOUT_EN to abort accesses that are not
//            acknowledged within 255 busy cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [4:0]  regD_in,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        is_byte,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic        wb_en,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_regD,
`ifdef MEM_TIMEOUT_EN
   output logic        timeout,
`endif
   output logic        misalign
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e      state_q,     state_d;
   logic        mem_req_q,   mem_req_d;
   logic        mem_we_q,    mem_we_d;
   logic [31:0] mem_addr_q,  mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q,    mem_be_d;
   logic        wb_valid_q,  wb_valid_d;
   logic        wb_en_q,     wb_en_d;
   logic [31:0] wb_data_q,   wb_data_d;
   logic [4:0]  wb_regD_q,   wb_regD_d;
   logic        misalign_q,  misalign_d;
   // Load bookkeeping kept for the write-back once the memory answers
   logic [4:0]  ld_regD_q,   ld_regD_d;
   logic        ld_byte_q,   ld_byte_d;
   logic [1:0]  ld_lane_q,   ld_lane_d;
`ifdef MEM_TIMEOUT_EN
   logic [7:0]  cnt_q,       cnt_d;
   logic        timeout_q,   timeout_d;
`endif

   logic        w_is_mem;
   logic        w_misal;
   logic        w_stall;

   assign w_is_mem = mem_read | mem_write;
   assign w_misal  = ~is_byte & (alu_result[1:0] != 2'b00);

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      wb_valid_d  = 1'b0;
      wb_en_d     = 1'b0;
      wb_data_d   = wb_data_q;
      wb_regD_d   = wb_regD_q;
      misalign_d  = misalign_q;
      ld_regD_d   = ld_regD_q;
      ld_byte_d   = ld_byte_q;
      ld_lane_d   = ld_lane_q;
      w_stall     = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d       = cnt_q;
      timeout_d   = timeout_q;
`endif
      if (state_q == IDLE) begin
         if (in_valid) begin
            if (!w_is_mem) begin
               wb_valid_d = 1'b1;
               wb_en_d    = (regD_in != 5'd0);
               wb_data_d  = alu_result;
               wb_regD_d  = regD_in;
            end else if (w_misal) begin
               // Rejected without touching memory; write-back is a no-op pulse
               misalign_d = 1'b1;
               wb_valid_d = 1'b1;
            end else begin
               w_stall     = 1'b1;
               state_d     = BUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = mem_write;   // read+write together acts as a write
               mem_addr_d  = {alu_result[31:2], 2'b00};
               mem_be_d    = is_byte ? (4'b0001 << alu_result[1:0]) : 4'b1111;
               mem_wdata_d = is_byte ? {4{store_data[7:0]}} : store_data;
               ld_regD_d   = regD_in;
               ld_byte_d   = is_byte;
               ld_lane_d   = alu_result[1:0];
`ifdef MEM_TIMEOUT_EN
               cnt_d       = 8'd0;
`endif
            end
         end
      end else begin
         if (mem_ack) begin
            state_d    = IDLE;
            mem_req_d  = 1'b0;
            wb_valid_d = 1'b1;
            if (!mem_we_q) begin
               wb_en_d   = (ld_regD_q != 5'd0);
               wb_regD_d = ld_regD_q;
               wb_data_d = ld_byte_q ? {24'd0, mem_rdata[{ld_lane_q, 3'b000} +: 8]}
                                     : mem_rdata;
            end
         end else begin
`ifdef MEM_TIMEOUT_EN
            // The 255th unanswered busy cycle is the last one
            if (cnt_q == 8'd254) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               wb_valid_d = 1'b1;
               timeout_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + 8'd1;
               w_stall = 1'b1;
            end
`else
            w_stall = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_be_q    <= 4'd0;
         wb_valid_q  <= 1'b0;
         wb_en_q     <= 1'b0;
         wb_data_q   <= 32'd0;
         wb_regD_q   <= 5'd0;
         misalign_q  <= 1'b0;
         ld_regD_q   <= 5'd0;
         ld_byte_q   <= 1'b0;
         ld_lane_q   <= 2'd0;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= 8'd0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         wb_valid_q  <= wb_valid_d;
         wb_en_q     <= wb_en_d;
         wb_data_q   <= wb_data_d;
         wb_regD_q   <= wb_regD_d;
         misalign_q  <= misalign_d;
         ld_regD_q   <= ld_regD_d;
         ld_byte_q   <= ld_byte_d;
         ld_lane_q   <= ld_lane_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   // Stall is combinational; masked during reset so upstream never freezes then
   assign stall     = w_stall & reset;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign wb_valid  = wb_valid_q;
   assign wb_en     = wb_en_q;
   assign wb_data   = wb_data_q;
   assign wb_regD   = wb_regD_q;
   assign misalign  = misalign_q;
`ifdef MEM_TIMEOUT_EN
   assign timeout   = timeout_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: directed scenarios followed
//            by random ALU/load/store traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] alu_result = '0;
   logic [31:0] store_data = '0;
   logic [4:0]  regD_in = '0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic        is_byte = 1'b0;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        wb_valid;
   logic        wb_en;
   logic [31:0] wb_data;
   logic [4:0]  wb_regD;
   logic        misalign;
`ifdef MEM_TIMEOUT_EN
   logic        timeout;
`endif

   int errors = 0;
   int checks = 0;

   // Behavioural model state: last delivered result and the sticky flag
   logic [31:0] m_wb_data = '0;
   logic [4:0]  m_wb_regD = '0;
   logic        m_misalign = 1'b0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .alu_result (alu_result),
      .store_data (store_data),
      .regD_in    (regD_in),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .is_byte    (is_byte),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .wb_valid   (wb_valid),
      .wb_en      (wb_en),
      .wb_data    (wb_data),
      .wb_regD    (wb_regD),
`ifdef MEM_TIMEOUT_EN
      .timeout    (timeout),
`endif
      .misalign   (misalign)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // op: 0 ALU, 1 load, 2 store, 3 read+write (acts as store)
   task automatic run_txn(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input logic byt, input int delay);
      logic       rd_op, wr_op, is_mem, mis;
      int         lane;
      logic [3:0] exp_be;
      logic [31:0] exp_wdata;
      rd_op  = (op == 1) || (op == 3);
      wr_op  = (op >= 2);
      is_mem = rd_op || wr_op;
      lane   = int'(addr % 4);
      mis    = is_mem && !byt && (lane != 0);

      in_valid = 1'b1; alu_result = addr; store_data = sdata; regD_in = rd;
      mem_read = rd_op; mem_write = wr_op; is_byte = byt;
      #1;
      chk("stall_accept", stall, is_mem && !mis);
      step();
      in_valid = 1'b0;

      if (!is_mem) begin
         m_wb_data = addr;
         m_wb_regD = rd;
         chk("alu_wb_valid", wb_valid, 1);
         chk("alu_wb_en",    wb_en, rd != 0);
         chk("alu_wb_data",  wb_data, m_wb_data);
         chk("alu_wb_regD",  wb_regD, m_wb_regD);
         chk("alu_mem_req",  mem_req, 0);
         chk("alu_stall",    stall, 0);
      end else if (mis) begin
         m_misalign = 1'b1;
         chk("mis_wb_valid", wb_valid, 1);
         chk("mis_wb_en",    wb_en, 0);
         chk("mis_mem_req",  mem_req, 0);
         chk("mis_stall",    stall, 0);
      end else begin
         exp_be    = byt ? 4'(32'd1 << lane) : 4'hF;
         exp_wdata = byt ? (sdata % 256) * 32'h0101_0101 : sdata;
         for (int d = 0; d <= delay; d++) begin
            mem_ack   = (d == delay);
            mem_rdata = (d == delay) ? rdata : $urandom;
            // Upstream noise while busy must be ignored
            in_valid   = 1'($urandom_range(0, 1));
            alu_result = $urandom;
            store_data = $urandom;
            regD_in    = 5'($urandom_range(0, 31));
            mem_read   = 1'($urandom_range(0, 1));
            mem_write  = 1'($urandom_range(0, 1));
            is_byte    = 1'($urandom_range(0, 1));
            #1;
            chk("busy_mem_req",  mem_req, 1);
            chk("busy_mem_we",   mem_we, wr_op);
            chk("busy_mem_addr", mem_addr, addr - 32'(lane));
            chk("busy_mem_be",   mem_be, exp_be);
            if (wr_op) chk("busy_mem_wdata", mem_wdata, exp_wdata);
            chk("busy_wb_valid", wb_valid, 0);
            chk("busy_stall",    stall, d < delay);
            step();
         end
         mem_ack  = 1'b0;
         in_valid = 1'b0;
         chk("done_mem_req",  mem_req, 0);
         chk("done_wb_valid", wb_valid, 1);
         chk("done_wb_en",    wb_en, !wr_op && (rd != 0));
         if (!wr_op) begin
            m_wb_data = byt ? (rdata >> (8 * lane)) % 256 : rdata;
            m_wb_regD = rd;
            chk("load_wb_data", wb_data, m_wb_data);
            chk("load_wb_regD", wb_regD, m_wb_regD);
         end
      end
      chk("misalign", misalign, m_misalign);

      // Gap cycle: a stray ack while idle does nothing; result held
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      step();
      mem_ack = 1'b0;
      chk("gap_wb_valid", wb_valid, 0);
      chk("gap_mem_req",  mem_req, 0);
      chk("gap_wb_data",  wb_data, m_wb_data);
      chk("gap_wb_regD",  wb_regD, m_wb_regD);
   endtask

   initial begin
      logic [31:0] a;
      int          n;

      // Reset state
      #12;
      in_valid = 1'b1; mem_read = 1'b1; alu_result = 32'h10;
      #1;
      chk("rst_stall",    stall, 0);
      chk("rst_mem_req",  mem_req, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_data",  wb_data, 0);
      chk("rst_mem_be",   mem_be, 0);
      chk("rst_misalign", misalign, 0);
      in_valid = 1'b0; mem_read = 1'b0;
      step();
      reset = 1'b1;
      step();

      // Directed scenarios
      run_txn(0, 32'h0000_0042, 32'h0, 32'h0, 5'd5, 1'b0, 0);
      run_txn(1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5'd3, 1'b0, 3);
      run_txn(2, 32'h0000_0203, 32'h0000_00A5, 32'h0, 5'd7, 1'b1, 1);
      run_txn(1, 32'h0000_0101, 32'h0, 32'h1122_3344, 5'd9, 1'b1, 0);
      run_txn(1, 32'h0000_0102, 32'h0, 32'h0, 5'd4, 1'b0, 0);
      run_txn(3, 32'h0000_0300, 32'h1234_5678, 32'h0, 5'd1, 1'b0, 2);
      run_txn(0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 1'b0, 0);

      // Reset during the second busy cycle of a load
      in_valid = 1'b1; alu_result = 32'h40; regD_in = 5'd4;
      mem_read = 1'b1; mem_write = 1'b0; is_byte = 1'b0;
      step();
      in_valid = 1'b0;
      step();
      reset = 1'b0;
      in_valid = 1'b1;
      #1;
      chk("arst_mem_req",   mem_req, 0);
      chk("arst_mem_we",    mem_we, 0);
      chk("arst_mem_addr",  mem_addr, 0);
      chk("arst_mem_wdata", mem_wdata, 0);
      chk("arst_mem_be",    mem_be, 0);
      chk("arst_wb_valid",  wb_valid, 0);
      chk("arst_wb_en",     wb_en, 0);
      chk("arst_wb_data",   wb_data, 0);
      chk("arst_wb_regD",   wb_regD, 0);
      chk("arst_misalign",  misalign, 0);
      chk("arst_stall",     stall, 0);
      m_wb_data = '0; m_wb_regD = '0; m_misalign = 1'b0;
      in_valid = 1'b0;
      step();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_ack = 1'b1; mem_rdata = $urandom;
         step();
         chk("stray_wb_valid", wb_valid, 0);
         chk("stray_mem_req",  mem_req, 0);
      end
      mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
      // Unanswered load must abort after 255 busy cycles
      in_valid = 1'b1; alu_result = 32'h80; regD_in = 5'd2;
      mem_read = 1'b1; mem_write = 1'b0; is_byte = 1'b0;
      step();
      in_valid = 1'b0;
      n = 0;
      while (mem_req && n < 300) begin
         n++;
         step();
      end
      chk("to_busy_cycles", 32'(n), 255);
      chk("to_timeout",     timeout, 1);
      chk("to_wb_valid",    wb_valid, 1);
      chk("to_wb_en",       wb_en, 0);
      chk("to_mem_req",     mem_req, 0);
      step();
`endif

      // Random traffic
      for (int t = 0; t < 60; t++) begin
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         run_txn(int'($urandom_range(0, 3)), a, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
